// File: rtl/core_wb.sv
// core_wb: write-back stage of the five-stage RV32 core.
// Accepts the mw_* bundle and selects the ALU/CSR result or the load data.
// Loads whose data is not yet present are held in WAIT_MEM until the data
// arrives. Each instruction commits with a one-cycle pulse on the registered
// register-file and CSR write ports.
// Optional feature: define CORE_WB_INSTRET_EN to build the 64-bit
// retired-instruction counter; otherwise instret is tied to 0.
module core_wb (
  input  logic        clk,
  input  logic        rest,
  input  logic        mw_valid,
  output logic        mw_ready,
  input  logic [31:0] mw_reg_data,
  input  logic [31:0] mw_mem_data,
  input  logic        mw_mem_data_valid,
  input  logic [31:0] mw_csr_data,
  input  logic [4:0]  mw_rd,
  input  logic        mw_reg_write,
  input  logic        mw_reg_write_sel,
  input  logic [11:0] mw_csr,
  input  logic        mw_csr_write,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        wb_load_pending,
  output logic [4:0]  wb_load_rd,
  output logic [63:0] instret
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic        hold_reg_write_q, hold_reg_write_d;
  logic        hold_csr_write_q, hold_csr_write_d;
  logic [11:0] hold_csr_q, hold_csr_d;
  logic [31:0] hold_csr_data_q, hold_csr_data_d;
  logic        rf_wr_en_q, rf_wr_en_d;
  logic [4:0]  rf_wr_addr_q, rf_wr_addr_d;
  logic [31:0] rf_wr_data_q, rf_wr_data_d;
  logic        csr_wr_en_q, csr_wr_en_d;
  logic [11:0] csr_wr_addr_q, csr_wr_addr_d;
  logic [31:0] csr_wr_data_q, csr_wr_data_d;

  // Fields of the instruction committing this cycle (bundle or held copy).
  logic        do_commit;
  logic [4:0]  c_rd;
  logic        c_reg_write;
  logic        c_csr_write;
  logic [11:0] c_csr;
  logic [31:0] c_csr_data;
  logic [31:0] c_data;

  // State and port registers; reset drops any pending wait or commit.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q          <= IDLE;
      hold_rd_q        <= '0;
      hold_reg_write_q <= 1'b0;
      hold_csr_write_q <= 1'b0;
      hold_csr_q       <= '0;
      hold_csr_data_q  <= '0;
      rf_wr_en_q       <= 1'b0;
      rf_wr_addr_q     <= '0;
      rf_wr_data_q     <= '0;
      csr_wr_en_q      <= 1'b0;
      csr_wr_addr_q    <= '0;
      csr_wr_data_q    <= '0;
    end else begin
      state_q          <= state_d;
      hold_rd_q        <= hold_rd_d;
      hold_reg_write_q <= hold_reg_write_d;
      hold_csr_write_q <= hold_csr_write_d;
      hold_csr_q       <= hold_csr_d;
      hold_csr_data_q  <= hold_csr_data_d;
      rf_wr_en_q       <= rf_wr_en_d;
      rf_wr_addr_q     <= rf_wr_addr_d;
      rf_wr_data_q     <= rf_wr_data_d;
      csr_wr_en_q      <= csr_wr_en_d;
      csr_wr_addr_q    <= csr_wr_addr_d;
      csr_wr_data_q    <= csr_wr_data_d;
    end
  end

  // Next state: accept, wait for load data, and form the commit strobes.
  always_comb begin
    state_d          = state_q;
    hold_rd_d        = hold_rd_q;
    hold_reg_write_d = hold_reg_write_q;
    hold_csr_write_d = hold_csr_write_q;
    hold_csr_d       = hold_csr_q;
    hold_csr_data_d  = hold_csr_data_q;
    rf_wr_en_d       = 1'b0;
    rf_wr_addr_d     = rf_wr_addr_q;
    rf_wr_data_d     = rf_wr_data_q;
    csr_wr_en_d      = 1'b0;
    csr_wr_addr_d    = csr_wr_addr_q;
    csr_wr_data_d    = csr_wr_data_q;
    do_commit        = 1'b0;
    c_rd             = hold_rd_q;
    c_reg_write      = hold_reg_write_q;
    c_csr_write      = hold_csr_write_q;
    c_csr            = hold_csr_q;
    c_csr_data       = hold_csr_data_q;
    c_data           = mw_reg_data;

    case (state_q)
      IDLE: begin
        if (mw_valid) begin
          hold_rd_d        = mw_rd;
          hold_reg_write_d = mw_reg_write;
          hold_csr_write_d = mw_csr_write;
          hold_csr_d       = mw_csr;
          hold_csr_data_d  = mw_csr_data;
          c_rd             = mw_rd;
          c_reg_write      = mw_reg_write;
          c_csr_write      = mw_csr_write;
          c_csr            = mw_csr;
          c_csr_data       = mw_csr_data;
          if (!mw_reg_write_sel) begin
            do_commit = 1'b1;
            c_data    = mw_reg_data;
          end else if (mw_mem_data_valid) begin
            do_commit = 1'b1;
            c_data    = mw_mem_data;
          end else begin
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (mw_mem_data_valid) begin
          do_commit = 1'b1;
          c_data    = mw_mem_data;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Address/data only move when their strobe fires, so they stay stable otherwise.
    if (do_commit) begin
      rf_wr_en_d  = c_reg_write && (c_rd != 5'd0);
      csr_wr_en_d = c_csr_write;
      if (rf_wr_en_d) begin
        rf_wr_addr_d = c_rd;
        rf_wr_data_d = c_data;
      end
      if (csr_wr_en_d) begin
        csr_wr_addr_d = c_csr;
        csr_wr_data_d = c_csr_data;
      end
    end
  end

  assign mw_ready        = (state_q == IDLE);
  assign wb_load_pending = (state_q == WAIT_MEM);
  assign wb_load_rd      = (state_q == WAIT_MEM) ? hold_rd_q : 5'd0;
  assign rf_wr_en        = rf_wr_en_q;
  assign rf_wr_addr      = rf_wr_addr_q;
  assign rf_wr_data      = rf_wr_data_q;
  assign csr_wr_en       = csr_wr_en_q;
  assign csr_wr_addr     = csr_wr_addr_q;
  assign csr_wr_data     = csr_wr_data_q;

`ifdef CORE_WB_INSTRET_EN
  logic        commit_q, commit_d;
  logic [63:0] instret_q, instret_d;

  // Counter advances at the end of each commit cycle; wraps naturally.
  always_comb begin
    commit_d  = do_commit;
    instret_d = instret_q + 64'(commit_q);
  end

  // Commit marker and retired-instruction counter registers.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      commit_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      commit_q  <= commit_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_core_wb.sv
// Self-checking bench for core_wb: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_core_wb;
  logic        clk = 1'b0;
  logic        rest;
  logic        mw_valid, mw_ready;
  logic [31:0] mw_reg_data, mw_mem_data, mw_csr_data;
  logic        mw_mem_data_valid;
  logic [4:0]  mw_rd;
  logic        mw_reg_write, mw_reg_write_sel;
  logic [11:0] mw_csr;
  logic        mw_csr_write;
  logic        rf_wr_en, csr_wr_en, wb_load_pending;
  logic [4:0]  rf_wr_addr, wb_load_rd;
  logic [31:0] rf_wr_data, csr_wr_data;
  logic [11:0] csr_wr_addr;
  logic [63:0] instret;

  always #5 clk = ~clk;

  core_wb dut (
    .clk(clk), .rest(rest),
    .mw_valid(mw_valid), .mw_ready(mw_ready),
    .mw_reg_data(mw_reg_data), .mw_mem_data(mw_mem_data),
    .mw_mem_data_valid(mw_mem_data_valid), .mw_csr_data(mw_csr_data),
    .mw_rd(mw_rd), .mw_reg_write(mw_reg_write),
    .mw_reg_write_sel(mw_reg_write_sel), .mw_csr(mw_csr),
    .mw_csr_write(mw_csr_write),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .wb_load_pending(wb_load_pending), .wb_load_rd(wb_load_rd),
    .instret(instret)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    bit          rw;
    bit          cw;
    logic [11:0] csr;
    logic [31:0] cdata;
    logic [31:0] data;
  } instr_t;

  // Model state: an outstanding load (if any), last write-port contents, retire count.
  bit          m_wait;
  instr_t      m_pend;
  bit          m_commit;
  logic [63:0] m_instret;
  bit          e_rf_en, e_csr_en;
  logic [4:0]  e_rf_addr;
  logic [31:0] e_rf_data, e_csr_data;
  logic [11:0] e_csr_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef CORE_WB_INSTRET_EN
    return m_instret;
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_reset();
    m_wait = 0; m_commit = 0; m_instret = '0;
    m_pend = '{rd: 5'd0, rw: 1'b0, cw: 1'b0, csr: 12'd0, cdata: 32'd0, data: 32'd0};
    e_rf_en = 0; e_csr_en = 0; e_rf_addr = '0; e_rf_data = '0;
    e_csr_addr = '0; e_csr_data = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    instr_t r;
    bit     fire;
    fire = 0;
    r = m_pend;
    m_instret = m_instret + (m_commit ? 64'd1 : 64'd0);
    if (!m_wait) begin
      if (mw_valid) begin
        r = '{rd: mw_rd, rw: mw_reg_write, cw: mw_csr_write, csr: mw_csr,
              cdata: mw_csr_data, data: 32'd0};
        if (!mw_reg_write_sel) begin
          r.data = mw_reg_data; fire = 1;
        end else if (mw_mem_data_valid) begin
          r.data = mw_mem_data; fire = 1;
        end else begin
          m_wait = 1; m_pend = r;
        end
      end
    end else if (mw_mem_data_valid) begin
      r.data = mw_mem_data; fire = 1; m_wait = 0;
    end
    m_commit = fire;
    e_rf_en  = fire && r.rw && (r.rd != 5'd0);
    e_csr_en = fire && r.cw;
    if (e_rf_en)  begin e_rf_addr = r.rd;   e_rf_data = r.data;   end
    if (e_csr_en) begin e_csr_addr = r.csr; e_csr_data = r.cdata; end
  endtask

  task automatic compare_all();
    chk("mw_ready", mw_ready, !m_wait);
    chk("wb_load_pending", wb_load_pending, m_wait);
    chk("wb_load_rd", wb_load_rd, m_wait ? m_pend.rd : 5'd0);
    chk("rf_wr_en", rf_wr_en, e_rf_en);
    chk("rf_wr_addr", rf_wr_addr, e_rf_addr);
    chk("rf_wr_data", rf_wr_data, e_rf_data);
    chk("csr_wr_en", csr_wr_en, e_csr_en);
    chk("csr_wr_addr", csr_wr_addr, e_csr_addr);
    chk("csr_wr_data", csr_wr_data, e_csr_data);
    chk("instret", instret, exp_instret());
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input bit sel, input bit dv, input logic [4:0] rd,
                       input bit rw, input bit cw, input logic [11:0] csr,
                       input logic [31:0] rdata, input logic [31:0] mdata,
                       input logic [31:0] cdata);
    mw_valid = v; mw_reg_write_sel = sel; mw_mem_data_valid = dv; mw_rd = rd;
    mw_reg_write = rw; mw_csr_write = cw; mw_csr = csr;
    mw_reg_data = rdata; mw_mem_data = mdata; mw_csr_data = cdata;
  endtask

  task automatic idle();
    drive(0, 0, 0, 5'd0, 0, 0, 12'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic do_reset();
    rest = 1'b1;
    #1;
    chk("rst_mw_ready", mw_ready, 1'b1);
    chk("rst_pending", wb_load_pending, 1'b0);
    chk("rst_load_rd", wb_load_rd, 5'd0);
    chk("rst_rf_en", rf_wr_en, 1'b0);
    chk("rst_rf_addr", rf_wr_addr, 5'd0);
    chk("rst_rf_data", rf_wr_data, 32'd0);
    chk("rst_csr_en", csr_wr_en, 1'b0);
    chk("rst_csr_addr", csr_wr_addr, 12'd0);
    chk("rst_csr_data", csr_wr_data, 32'd0);
    chk("rst_instret", instret, 64'd0);
    model_reset();
    #2;
    rest = 1'b0;
  endtask

  initial begin
    rest = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Back-to-back ALU writes rd=1,2,3.
    drive(1, 0, 0, 5'd1, 1, 0, 12'd0, 32'h11, 32'h0, 32'h0); tick();
    chk("b2b_en1", rf_wr_en, 1'b1); chk("b2b_addr1", rf_wr_addr, 5'd1); chk("b2b_data1", rf_wr_data, 32'h11);
    drive(1, 0, 0, 5'd2, 1, 0, 12'd0, 32'h22, 32'h0, 32'h0); tick();
    chk("b2b_en2", rf_wr_en, 1'b1); chk("b2b_addr2", rf_wr_addr, 5'd2); chk("b2b_data2", rf_wr_data, 32'h22);
    drive(1, 0, 0, 5'd3, 1, 0, 12'd0, 32'h33, 32'h0, 32'h0); tick();
    chk("b2b_en3", rf_wr_en, 1'b1); chk("b2b_addr3", rf_wr_addr, 5'd3); chk("b2b_data3", rf_wr_data, 32'h33);
    idle(); tick();
    chk("b2b_en_off", rf_wr_en, 1'b0);
    chk("b2b_data_held", rf_wr_data, 32'h33);
`ifdef CORE_WB_INSTRET_EN
    chk("b2b_instret", instret, 64'd3);
`else
    chk("b2b_instret", instret, 64'd0);
`endif
    $display("[TB] back-to-back ALU done");

    // Load rd=5 with data arriving 4 cycles after the accept.
    drive(1, 1, 0, 5'd5, 1, 0, 12'd0, 32'h0, 32'h0, 32'h0); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("ld_ready_low", mw_ready, 1'b0);
      chk("ld_pending", wb_load_pending, 1'b1);
      chk("ld_rd", wb_load_rd, 5'd5);
      chk("ld_no_wr", rf_wr_en, 1'b0);
      tick();
    end
    drive(0, 0, 1, 5'd0, 0, 0, 12'd0, 32'h0, 32'hDEADBEEF, 32'h0); tick();
    chk("ld_en", rf_wr_en, 1'b1); chk("ld_addr", rf_wr_addr, 5'd5);
    chk("ld_data", rf_wr_data, 32'hDEADBEEF); chk("ld_ready_back", mw_ready, 1'b1);
    $display("[TB] late-data load done");

    // x0 write suppressed, CSR write performed.
    drive(1, 0, 0, 5'd0, 1, 1, 12'h300, 32'h5, 32'h0, 32'h8); tick();
    chk("x0_rf_en", rf_wr_en, 1'b0); chk("csr_en", csr_wr_en, 1'b1);
    chk("csr_addr", csr_wr_addr, 12'h300); chk("csr_data", csr_wr_data, 32'h8);
    $display("[TB] x0 + CSR write done");

    // Stray data-valid in IDLE.
    drive(0, 0, 1, 5'd9, 1, 1, 12'h1, 32'h1, 32'h77, 32'h1); tick();
    chk("stray_rf_en", rf_wr_en, 1'b0); chk("stray_csr_en", csr_wr_en, 1'b0);
    chk("stray_ready", mw_ready, 1'b1);
    $display("[TB] stray data-valid done");

    // Reset during WAIT_MEM, then a late data pulse must not commit.
    drive(1, 1, 0, 5'd7, 1, 0, 12'd0, 32'h0, 32'h0, 32'h0); tick();
    chk("rw_pending", wb_load_pending, 1'b1);
    idle();
    do_reset();
    drive(0, 0, 1, 5'd0, 0, 0, 12'd0, 32'h0, 32'hCAFE, 32'h0); tick();
    chk("rw_no_commit", rf_wr_en, 1'b0);
    $display("[TB] reset mid-wait done");

`ifdef CORE_WB_INSTRET_EN
    idle(); tick();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1, 0, 0, 5'd4, 1, 0, 12'd0, 32'h4, 32'h0, 32'h0); tick();
    idle(); tick();
    chk("wrap_instret", instret, 64'd0);
    $display("[TB] counter wrap done");
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        idle();
        do_reset();
      end
      drive(($urandom % 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            12'($urandom), $urandom, $urandom, $urandom);
      tick();
    end
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/core_wb.md
# core_wb

Write-back stage of the five-stage RV32 core. It sits directly downstream of the memory-access stage and consumes that stage's `mw_*` bundle. It selects the ALU/CSR result or the load data, waits for outstanding load data, and drives the register-file and CSR write ports. It also exports forwarding and hazard information, plus an optional retired-instruction counter.

## Interface
- No parameters.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rest` in 1: asynchronous, active-high reset.
- `mw_valid` in 1: the `mw_*` bundle holds an instruction.
- `mw_ready` out 1: the stage can accept; this is combinational, equal to (state == IDLE).
- `mw_reg_data` in 32: ALU or CSR result for the rd write.
- `mw_mem_data` in 32: load data, already aligned and extended by the LSU.
- `mw_mem_data_valid` in 1: `mw_mem_data` is valid in this cycle (pulse).
- `mw_csr_data` in 32: CSR write value.
- `mw_rd` in 5: destination register.
- `mw_reg_write` in 1: the instruction writes rd.
- `mw_reg_write_sel` in 1: 0 selects `mw_reg_data`; 1 selects `mw_mem_data` (load).
- `mw_csr` in 12: CSR address.
- `mw_csr_write` in 1: the instruction writes a CSR.
- `rf_wr_en` out 1: register-file write strobe.
- `rf_wr_addr` out 5: register-file write address.
- `rf_wr_data` out 32: register-file write data.
- `csr_wr_en` out 1: CSR write strobe.
- `csr_wr_addr` out 12: CSR write address.
- `csr_wr_data` out 32: CSR write data.
- `wb_load_pending` out 1: a load is held waiting for data; hazard unit stalls on an rd match.
- `wb_load_rd` out 5: rd of the pending load.
- `instret` out 64: count of retired instructions.

## Operation
- The FSM has two states: IDLE and WAIT_MEM. Reset state is IDLE.
- **Accept:** an accept happens in a cycle with `mw_valid & mw_ready`. The bundle is captured into holding registers on that rising edge.
- **Non-load accept** (`mw_reg_write_sel`=0): commits on the next cycle with data `mw_reg_data`. State stays IDLE.
- **Load accept with data present** (`mw_reg_write_sel`=1 and `mw_mem_data_valid`=1 in the accept cycle): `mw_mem_data` is captured, and the load commits on the next cycle. State stays IDLE.
- **Load accept without data** (`mw_reg_write_sel`=1 and `mw_mem_data_valid`=0): state moves to WAIT_MEM.
- **WAIT_MEM:**
  - `mw_ready`=0.
  - `wb_load_pending`=1 and `wb_load_rd` = held rd.
  - On the first cycle with `mw_mem_data_valid`=1, `mw_mem_data` is captured, state returns to IDLE, and the load commits on the next cycle.
  - WAIT_MEM waits with no timeout.
- **Commit cycle:** asserted for exactly one cycle per accepted instruction.
  - `rf_wr_en` = held `reg_write` AND (held rd ≠ 0). Writes to x0 are suppressed, but the instruction still retires.
  - `csr_wr_en` = held `csr_write`. It is independent of the rd write; both strobes may assert in the same cycle.
- A load with `reg_write`=0 still waits for its data before retiring.
- `mw_mem_data_valid` pulses are ignored in IDLE unless a load is being accepted in that same cycle.
- **Reset mid-operation:** any pending commit or WAIT_MEM is discarded. All outputs return to their reset values.

## Timing
- **Reset values:** every output is 0, including `instret`. Exception: `mw_ready`=1, because the state is IDLE.
- **Latency:** one cycle from the accept edge to the commit strobes for non-loads and data-present loads. For waiting loads, one cycle from the data-valid edge to the commit.
- **Throughput:** one non-load instruction per cycle, back-to-back.
- **Load stall:** `mw_ready` is low from the cycle after the accept until the data-valid edge. It is high again in the commit cycle, so a new accept can overlap the commit.
- **Write-port outputs:** `rf_wr_*` and `csr_wr_*` are registered. Address and data are held stable while the strobes are low.

## Configuration
- Macro `CORE_WB_INSTRET_EN`:
  - **Defined:** `instret` is a 64-bit counter. It increments by 1 in every commit cycle, wraps from 2^64−1 to 0, and is cleared by `rest`.
  - **Undefined:** `instret` is tied to 0 and no counter logic is built.

## Test plan
- **Back-to-back ALU:** 3 accepts in consecutive cycles with rd=1,2,3 and data 0x11,0x22,0x33 -> `rf_wr_en` high for 3 consecutive cycles, starting one cycle after the first accept, with matching address/data; `instret`=3.
- **Load with late data:** load rd=5 accepted with `mw_mem_data_valid`=0; valid arrives 4 cycles later with 0xDEADBEEF -> `mw_ready`=0 and `wb_load_pending`=1 with `wb_load_rd`=5 during the wait; one cycle after the valid edge, `rf_wr_en`=1, `rf_wr_addr`=5, `rf_wr_data`=0xDEADBEEF.
- **x0 write plus CSR write:** rd=0, `reg_write`=1, `csr_write`=1, `csr`=0x300, `csr_data`=0x8 -> `rf_wr_en`=0; `csr_wr_en`=1 with `csr_wr_addr`=0x300 and `csr_wr_data`=0x8; `instret` increments.
- **Stray data-valid:** `mw_mem_data_valid` pulses in IDLE with `mw_valid`=0 -> no strobes, state stays IDLE.
- **Reset mid-wait:** `rest` asserted while in WAIT_MEM -> all outputs 0 and `mw_ready`=1 immediately; a later data-valid pulse produces no commit.
- **Counter wrap (macro defined):** force `instret`=0xFFFF_FFFF_FFFF_FFFF, commit one instruction -> `instret`=0. With the macro undefined, `instret` stays 0 throughout.
